// File: rtl/serial_operand_tx_pkg.sv
// Shared serial-datapath definitions: stream framing states and the default operand width.
package serial_operand_tx_pkg;
    localparam int SERIAL_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} sop_state_e;
endpackage

// File: rtl/serial_operand_tx_if.sv
// Operand request handshake plus serial bit-pair stream to the ALU/branch consumers.
interface serial_operand_tx_if
    import serial_operand_tx_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_en;
    logic             out_clr;
    logic             out_valid;
    logic             out_a;
    logic             out_b;
    logic             out_cin;
    logic             out_first;
    logic             out_last;
    logic             done;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_en,
        input  in_ready, out_clr, out_valid, out_a, out_b, out_cin, out_first, out_last, done
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_en,
        output in_ready, out_clr, out_valid, out_a, out_b, out_cin, out_first, out_last, done
    );
endinterface

// File: rtl/serial_operand_tx_shift_reg.sv
// Parallel-load, right-shifting register exposing bit 0; zero fill from the top.
module serial_shift_reg
    import serial_operand_tx_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    output logic             bit0
);
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else if (load)
            sr <= load_val;
        else if (shift)
            sr <= {1'b0, sr[WIDTH-1:1]};
    end

    assign bit0 = sr[0];
endmodule

// File: rtl/serial_operand_tx.sv
// Bit-serial operand transmitter: latches A/B/sub, then streams LSB-first bit pairs
// framed by a clear pulse, first/last markers and a done pulse.
module serial_operand_tx
    import serial_operand_tx_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    serial_operand_tx_if.slave  bus
);
    sop_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             sub_q;
    logic             ready_q, clr_q, valid_q, first_q, last_q, done_q;
    logic             a_bit, b_bit;
    logic             load, shift;

    assign load  = (state == IDLE) && bus.in_valid;
    assign shift = (state == SHIFT) && bus.out_en;

    serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .clk(clk), .rst(rst), .load(load), .load_val(bus.in_a), .shift(shift), .bit0(a_bit)
    );
    serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .clk(clk), .rst(rst), .load(load), .load_val(bus.in_b), .shift(shift), .bit0(b_bit)
    );

    // Framing flags are registered alongside the state so outputs never see in_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sub_q   <= 1'b0;
            ready_q <= 1'b1;
            clr_q   <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state   <= CLR;
                    cnt     <= '0;
                    sub_q   <= bus.in_sub;
                    ready_q <= 1'b0;
                    clr_q   <= 1'b1;
                end
                CLR: begin
                    state   <= SHIFT;
                    clr_q   <= 1'b0;
                    valid_q <= 1'b1;
                    first_q <= 1'b1;
                    last_q  <= 1'b0;
                end
                SHIFT: if (bus.out_en) begin
                    first_q <= 1'b0;
                    if (last_q) begin
                        // cnt parks at its terminal value rather than wrapping
                        state   <= DONE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        last_q <= (cnt == CNT_W'(WIDTH - 2));
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_clr   = clr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_a     = valid_q & a_bit;
    assign bus.out_b     = valid_q & (b_bit ^ sub_q);
    assign bus.out_cin   = valid_q & first_q & sub_q;
    assign bus.out_first = valid_q & first_q;
    assign bus.out_last  = valid_q & last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: vector table of operand ops with a bit-level scoreboard
// and a serial adder rebuilding the sum, plus backpressure and mid-stream reset sequences.
module tb_serial_operand_tx;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_operand_tx_if #(.WIDTH(W)) bus ();
    serial_operand_tx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic a, b, cin, first, last;
    } bit_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        int           mode;     // 0: out_en always 1, 1: 1,0,0,1 pattern, 2: random
        logic [W-1:0] exp_sum;
    } vec_t;

    bit_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         mon_en = 1'b0;
    int           popped = 0;
    logic [W-1:0] sum_acc = '0;
    logic         carry = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid cycle is checked (stalled cycles must hold); consumed bits pop.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    bit_t e;
                    logic cin_eff;
                    int bi;
                    e = exp_q[0];
                    chk("bit", {bus.out_a, bus.out_b, bus.out_cin, bus.out_first, bus.out_last},
                        {e.a, e.b, e.cin, e.first, e.last});
                    if (bus.out_en) begin
                        void'(exp_q.pop_front());
                        bi      = e.first ? 0 : popped;
                        cin_eff = e.first ? bus.out_cin : carry;
                        sum_acc[bi] = bus.out_a ^ bus.out_b ^ cin_eff;
                        carry   = (bus.out_a & bus.out_b) | (bus.out_a & cin_eff) | (bus.out_b & cin_eff);
                        popped  = bi + 1;
                    end
                end
            end else begin
                chk("idle_bits_zero", {bus.out_a, bus.out_b, bus.out_cin, bus.out_first, bus.out_last}, 0);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int mode, input logic [W-1:0] exp_sum, input int rst_bit,
                          input logic hold, input logic [W-1:0] a2, input logic [W-1:0] b2,
                          input logic sub2);
        int k, p, stalls, w;
        logic en, got_done, early_ready, dflag;
        for (int i = 0; i < W; i++)
            exp_q.push_back('{a[i], b[i] ^ sub, sub && (i == 0), i == 0, i == W - 1});
        popped      = 0;
        bus.in_a    = a;
        bus.in_b    = b;
        bus.in_sub  = sub;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            exp_q.delete();
            return;
        end
        @(posedge clk); #1;
        if (hold) begin
            bus.in_a   = a2;
            bus.in_b   = b2;
            bus.in_sub = sub2;
        end else begin
            bus.in_valid = 1'b0;
        end
        k = 0; p = 0; stalls = 0;
        got_done = 1'b0; early_ready = 1'b0;
        while (k < 400) begin
            if (rst_bit >= 0 && bus.out_valid && popped == rst_bit) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk("rst_ready", bus.in_ready, 1);
                chk("rst_outs", {bus.out_clr, bus.out_valid, bus.out_a, bus.out_b, bus.out_cin,
                                 bus.out_first, bus.out_last, bus.done}, 0);
                dflag = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (bus.done) dflag = 1'b1;
                end
                chk("no_done_after_rst", dflag, 0);
                return;
            end
            if (bus.out_valid) begin
                case (mode)
                    0:       en = 1'b1;
                    1:       en = (p % 4 == 0) || (p % 4 == 3);
                    default: en = 1'($urandom_range(0, 1));
                endcase
                if (!en) stalls++;
                p++;
            end else begin
                en = 1'($urandom_range(0, 1));
            end
            bus.out_en = en;
            @(negedge clk);
            k++;
            if (k == 1) chk("clr_pulse", {bus.out_clr, bus.out_valid}, 2'b10);
            if (k == 2) chk("bit0_after_clr", {bus.out_clr, bus.out_valid, bus.out_first}, 3'b011);
            if (bus.done) begin
                got_done = 1'b1;
                chk("done_latency", k, W + 2 + stalls);
                chk("bits_left", exp_q.size(), 0);
                chk("serial_sum", sum_acc, exp_sum);
                chk("ne_flag", (sum_acc != 0), (exp_sum != 0));
                break;
            end
            if (bus.in_ready) early_ready = 1'b1;
            @(posedge clk); #1;
        end
        if (!got_done) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end
        chk("ready_low_busy", early_ready, 0);
        @(posedge clk); #1;
        bus.out_en = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("ready_back", {bus.in_ready, bus.done}, 2'b10);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 0, 32'h0000_0008};
        vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, 32'h7FFF_FFFF};
        vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1, 32'hACF1_3568};
        vecs[4] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 2, 32'hFFFF_FFFF};
        vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1, 32'hFFFF_FFFF};

        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_sub   = 1'b0;
        bus.out_en   = 1'b1;
        rst          = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ready", bus.in_ready, 1);
        chk("reset_outs", {bus.out_clr, bus.out_valid, bus.out_a, bus.out_b, bus.out_cin,
                           bus.out_first, bus.out_last, bus.done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].mode, vecs[v].exp_sum,
                   -1, 1'b0, '0, '0, 1'b0);

        // Backpressure: second request held during the first stream, taken in the first IDLE cycle.
        run_op(32'h11, 32'h22, 1'b0, 0, 32'h33, -1, 1'b1, 32'h33, 32'h44, 1'b1);
        run_op(32'h33, 32'h44, 1'b1, 0, 32'hFFFF_FFEF, -1, 1'b0, '0, '0, 1'b0);

        // Reset at bit 10 abandons the stream; the next request starts cleanly at bit 0.
        run_op(32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b0, 0, 32'h0, 10, 1'b0, '0, '0, 1'b0);
        run_op(32'h7, 32'h7, 1'b0, 0, 32'hE, -1, 1'b0, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
